// File: rtl/mpx_divider.sv
// mpx_divider: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces a one-cycle strobe carrying HI (remainder) and LO (quotient).
module mpx_divider #(
  parameter int SUPPORT_MULDIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_rs_operand_i,
  input  logic [31:0] opcode_rt_operand_i,
  input  logic        squash_muldiv_i,
  output logic        div_busy_o,
  output logic        div_result_valid_o,
  output logic [31:0] div_result_hi_o,
  output logic [31:0] div_result_lo_o
);

  localparam bit EN = (SUPPORT_MULDIV != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  count;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        valid;

  logic        is_special;
  logic        is_div;
  logic        is_divu;
  logic        accept;
  logic        finish;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic        unused_fields;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  assign unused_fields = ^opcode_opcode_i[25:6];

  assign is_special = (opcode_opcode_i[31:26] == 6'h00);
  assign is_div     = is_special && (opcode_opcode_i[5:0] == 6'h1A);
  assign is_divu    = is_special && (opcode_opcode_i[5:0] == 6'h1B);
  assign accept     = EN && opcode_valid_i && (is_div || is_divu);

  // FIX completes only when neither a new divide nor a squash intervenes
  assign finish = (state == FIX) && !accept && !squash_muldiv_i;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign shifted = {rem, dividend[31]};
  assign diff    = shifted - {1'b0, divisor};
  assign ge      = (shifted >= {1'b0, divisor});

  // Next-state logic; a new accept always restarts from load
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (accept)               state_next = RUN;
        else if (squash_muldiv_i) state_next = IDLE;
        else if (count == 6'd31)  state_next = FIX;
      end
      FIX: begin
        if (accept) state_next = RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Operand load, iteration and sign fix-up of the result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count    <= 6'd0;
      dividend <= 32'd0;
      divisor  <= 32'd0;
      rem      <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      valid    <= 1'b0;
    end else begin
      valid <= finish;
      if (accept) begin
        count <= 6'd0;
        rem   <= 32'd0;
        if (is_div) begin
          dividend <= mag(opcode_rs_operand_i);
          divisor  <= mag(opcode_rt_operand_i);
          q_neg    <= opcode_rs_operand_i[31] ^ opcode_rt_operand_i[31];
          r_neg    <= opcode_rs_operand_i[31];
        end else begin
          dividend <= opcode_rs_operand_i;
          divisor  <= opcode_rt_operand_i;
          q_neg    <= 1'b0;
          r_neg    <= 1'b0;
        end
      end else if (state == RUN) begin
        count    <= count + 6'd1;
        rem      <= ge ? diff[31:0] : shifted[31:0];
        dividend <= {dividend[30:0], ge};
      end
      if (finish) begin
        lo <= q_neg ? (~dividend + 32'd1) : dividend;
        hi <= r_neg ? (~rem + 32'd1) : rem;
      end
    end
  end

  assign div_busy_o         = (state != IDLE);
  assign div_result_valid_o = valid;
  assign div_result_hi_o    = hi;
  assign div_result_lo_o    = lo;

endmodule

// File: tb/tb_mpx_divider.sv
// tb_mpx_divider: randomized and directed checks of mpx_divider
// against an arithmetic reference model.
module tb_mpx_divider;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        opcode_valid_i = 1'b0;
  logic [31:0] opcode_opcode_i = 32'd0;
  logic [31:0] opcode_rs_operand_i = 32'd0;
  logic [31:0] opcode_rt_operand_i = 32'd0;
  logic        squash_muldiv_i = 1'b0;
  logic        div_busy_o;
  logic        div_result_valid_o;
  logic [31:0] div_result_hi_o;
  logic [31:0] div_result_lo_o;

  mpx_divider #(.SUPPORT_MULDIV(1)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .opcode_valid_i      (opcode_valid_i),
    .opcode_opcode_i     (opcode_opcode_i),
    .opcode_rs_operand_i (opcode_rs_operand_i),
    .opcode_rt_operand_i (opcode_rt_operand_i),
    .squash_muldiv_i     (squash_muldiv_i),
    .div_busy_o          (div_busy_o),
    .div_result_valid_o  (div_result_valid_o),
    .div_result_hi_o     (div_result_hi_o),
    .div_result_lo_o     (div_result_lo_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] OP_DIV   = 32'h0000_001A;
  localparam logic [31:0] OP_DIVU  = 32'h0000_001B;
  localparam logic [31:0] OP_MULT  = 32'h0000_0018;
  localparam logic [31:0] OP_SYSC  = 32'h0000_000C;

  int n_pass = 0;
  int n_total = 0;

  int cyc = 0;
  int busy_cnt = 0;
  int busy_last = -1;
  int dbl = 0;
  logic prev_valid = 1'b0;
  int          s_cyc[$];
  logic [31:0] s_hi[$];
  logic [31:0] s_lo[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Observe outputs mid-cycle: busy history and every result strobe
  always @(negedge clk_i) begin
    if (div_busy_o) begin
      busy_cnt  <= busy_cnt + 1;
      busy_last <= cyc;
    end
    if (div_result_valid_o) begin
      s_cyc.push_back(cyc);
      s_hi.push_back(div_result_hi_o);
      s_lo.push_back(div_result_lo_o);
      if (prev_valid) dbl <= dbl + 1;
    end
    prev_valid <= div_result_valid_o;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: magnitudes divided with plain arithmetic, then signs applied
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] ma, mb, q, r, h, l;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (mb == 0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    l = (sgn && (a[31] ^ b[31])) ? -q : q;
    h = (sgn && a[31]) ? -r : r;
    return {h, l};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    opcode_valid_i      = 1'b1;
    opcode_opcode_i     = op;
    opcode_rs_operand_i = a;
    opcode_rt_operand_i = b;
  endtask

  task automatic undrive();
    opcode_valid_i = 1'b0;
    opcode_opcode_i = 32'd0;
  endtask

  task automatic run_div(input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
    int n0, b0, acc;
    logic [63:0] e;
    n0 = s_cyc.size();
    b0 = busy_cnt;
    acc = cyc;
    drive(sgn ? OP_DIV : OP_DIVU, a, b);
    step(1);
    undrive();
    step(36);
    e = model(sgn, a, b);
    check({tag, "_nstrobe"}, 32'(s_cyc.size() - n0), 32'd1);
    check({tag, "_busy"}, 32'(busy_cnt - b0), 32'd33);
    if (s_cyc.size() > n0) begin
      check({tag, "_cyc"}, 32'(s_cyc[n0] - acc), 32'd34);
      check({tag, "_lo"}, s_lo[n0], e[31:0]);
      check({tag, "_hi"}, s_hi[n0], e[63:32]);
    end
  endtask

  initial begin
    int n0, b0, acc, acc2;
    logic [63:0] e;
    logic [31:0] a, b;
    bit sg;

    step(3);
    rst_i = 1'b0;
    step(1);
    check("rst_busy", 32'(div_busy_o), 32'd0);
    check("rst_valid", 32'(div_result_valid_o), 32'd0);
    check("rst_hi", div_result_hi_o, 32'd0);
    check("rst_lo", div_result_lo_o, 32'd0);

    // DIVU 100/7 with exact busy window
    n0 = s_cyc.size();
    acc = cyc;
    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    check("divu_busy_last", 32'(busy_last - acc), 32'd33);
    check("hold_hi", div_result_hi_o, 32'd2);
    check("hold_lo", div_result_lo_o, 32'd14);

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_div(1'b0, 32'd5, 32'd0, "divu_by0");
    run_div(1'b1, 32'hFFFF_FFF6, 32'd0, "div_neg_by0");
    run_div(1'b1, 32'd9, 32'd0, "div_pos_by0");

    for (int i = 0; i < 30; i++) begin
      sg = $urandom_range(0, 1) == 1;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = b >> $urandom_range(1, 31);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_div(sg, a, b, "rand");
    end

    // Restart: second accept 10 cycles after the first
    n0 = s_cyc.size();
    b0 = busy_cnt;
    drive(OP_DIVU, 32'd100, 32'd7);
    step(1);
    undrive();
    step(9);
    acc2 = cyc;
    drive(OP_DIVU, 32'd9, 32'd4);
    step(1);
    undrive();
    step(36);
    check("restart_nstrobe", 32'(s_cyc.size() - n0), 32'd1);
    check("restart_busy", 32'(busy_cnt - b0), 32'd43);
    if (s_cyc.size() > n0) begin
      check("restart_cyc", 32'(s_cyc[n0] - acc2), 32'd34);
      check("restart_lo", s_lo[n0], 32'd2);
      check("restart_hi", s_hi[n0], 32'd1);
    end

    // Squash at C+20
    n0 = s_cyc.size();
    drive(OP_DIVU, 32'd100, 32'd7);
    step(1);
    undrive();
    step(19);
    squash_muldiv_i = 1'b1;
    step(1);
    squash_muldiv_i = 1'b0;
    check("squash_busy", 32'(div_busy_o), 32'd0);
    step(20);
    check("squash_nstrobe", 32'(s_cyc.size() - n0), 32'd0);

    // Squash with same-cycle accept
    n0 = s_cyc.size();
    drive(OP_DIV, 32'd100, 32'd7);
    step(1);
    undrive();
    step(5);
    squash_muldiv_i = 1'b1;
    acc2 = cyc;
    drive(OP_DIVU, 32'd9, 32'd4);
    step(1);
    squash_muldiv_i = 1'b0;
    undrive();
    step(36);
    check("sqacc_nstrobe", 32'(s_cyc.size() - n0), 32'd1);
    if (s_cyc.size() > n0) begin
      check("sqacc_cyc", 32'(s_cyc[n0] - acc2), 32'd34);
      check("sqacc_lo", s_lo[n0], 32'd2);
      check("sqacc_hi", s_hi[n0], 32'd1);
    end

    // Reset at C+5
    n0 = s_cyc.size();
    drive(OP_DIVU, 32'd100, 32'd7);
    step(1);
    undrive();
    step(4);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check("mid_rst_busy", 32'(div_busy_o), 32'd0);
    check("mid_rst_valid", 32'(div_result_valid_o), 32'd0);
    check("mid_rst_hi", div_result_hi_o, 32'd0);
    check("mid_rst_lo", div_result_lo_o, 32'd0);
    step(40);
    check("mid_rst_nstrobe", 32'(s_cyc.size() - n0), 32'd0);

    // Non-divide opcodes leave results untouched
    run_div(1'b0, 32'd1000, 32'd3, "pre_nondiv");
    e = model(1'b0, 32'd1000, 32'd3);
    n0 = s_cyc.size();
    b0 = busy_cnt;
    drive(OP_MULT, 32'd50, 32'd3);
    step(1);
    drive(OP_SYSC, 32'd50, 32'd3);
    step(1);
    undrive();
    step(40);
    check("nondiv_nstrobe", 32'(s_cyc.size() - n0), 32'd0);
    check("nondiv_busy", 32'(busy_cnt - b0), 32'd0);
    check("nondiv_hold_hi", div_result_hi_o, e[63:32]);
    check("nondiv_hold_lo", div_result_lo_o, e[31:0]);

    check("no_back_to_back", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
